// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// Parametrised VGA timing generator and pixel output stage.
//
// Counts pixels/lines for a VESA-style mode (active, front porch, sync, back
// porch), publishes the current coordinate to an external renderer, and takes
// the renderer's colour back PIPE cycles later. Sync and blanking are delayed
// by the same amount, so colour and sync line up at the connector.
//
// Optional feature (compile-time macro VGA_TEST_PATTERN_EN):
//   adds input test_mode; when high the renderer colour is replaced by eight
//   vertical colour bars, delayed exactly like the normal colour path.
//
// Ports:
//   pixel_clock   in   pixel clock
//   reset         in   asynchronous, active-high reset
//   ce            in   clock enable; all state holds while low
//   test_mode     in   (VGA_TEST_PATTERN_EN only) select colour-bar pattern
//   x, y          out  current coordinate (h_cnt, v_cnt), straight from regs
//   pix_req       out  coordinate lies in the active area (combinational)
//   line_start    out  h_cnt == 0 (combinational)
//   frame_start   out  h_cnt == 0 and v_cnt == 0 (combinational)
//   red_in..      in   renderer colour, valid PIPE cycles after pix_req
//   h_sync/v_sync out  registered syncs at configured polarity
//   de            out  registered, delayed active-video flag
//   red..blue     out  registered colour, zero outside active video

module vga_timing_ctrl #(
    parameter int unsigned H_ADDR = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_ADDR = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter int unsigned H_POL  = 0,
    parameter int unsigned V_POL  = 0,
    parameter int unsigned CNT_W  = 10,
    parameter int unsigned R_W    = 3,
    parameter int unsigned G_W    = 3,
    parameter int unsigned B_W    = 2,
    parameter int unsigned PIPE   = 2
) (
    input  logic             pixel_clock,
    input  logic             reset,
    input  logic             ce,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             pix_req,
    output logic             line_start,
    output logic             frame_start,
    input  logic [R_W-1:0]   red_in,
    input  logic [G_W-1:0]   green_in,
    input  logic [B_W-1:0]   blue_in,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic [R_W-1:0]   red,
    output logic [G_W-1:0]   green,
    output logic [B_W-1:0]   blue
);

    localparam int unsigned H_TOTAL = H_ADDR + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ADDR + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ADDR);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ADDR);
    localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ADDR + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ADDR + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ADDR + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ADDR + V_FP + V_SYNC);

    localparam logic HS_ACT = 1'(H_POL);
    localparam logic VS_ACT = 1'(V_POL);

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ADDR / 8;
    // payload: {test_mode, bar[2:0], pix_req, vs_raw, hs_raw}
    localparam int unsigned DW = 7;
`else
    // payload: {pix_req, vs_raw, hs_raw}
    localparam int unsigned DW = 3;
`endif

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hs_raw;
    logic             vs_raw;
    logic [DW-1:0]    pay_in;
    logic [DW-1:0]    tap;
    logic             tap_hs;
    logic             tap_vs;
    logic             tap_pr;
    logic [R_W-1:0]   col_r;
    logic [G_W-1:0]   col_g;
    logic [B_W-1:0]   col_b;

    // Pixel/line counters; vertical advances on the horizontal wrap.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + CNT_W'(1);
                end
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // Coordinate-time decodes.
    assign x           = h_cnt;
    assign y           = v_cnt;
    assign pix_req     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign line_start  = (h_cnt == '0);
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign hs_raw      = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
    assign vs_raw      = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
    logic       tap_tm;
    logic [2:0] tap_bar;

    // Bar index; anything past bar 7 lies in blanking and is masked by de.
    assign bar     = 3'(h_cnt / CNT_W'(BAR_W));
    assign pay_in  = {test_mode, bar, pix_req, vs_raw, hs_raw};
    assign tap_tm  = tap[6];
    assign tap_bar = tap[5:3];
`else
    assign pay_in  = {pix_req, vs_raw, hs_raw};
`endif

    assign tap_hs = tap[0];
    assign tap_vs = tap[1];
    assign tap_pr = tap[2];

    // PIPE-stage delay matching the renderer latency; zero means pass-through.
    generate
        if (PIPE > 0) begin : g_dly
            logic [DW-1:0] dly [PIPE];

            always_ff @(posedge pixel_clock or posedge reset) begin
                if (reset) begin
                    for (int unsigned i = 0; i < PIPE; i++) begin
                        dly[i] <= '0;
                    end
                end else if (ce) begin
                    dly[0] <= pay_in;
                    for (int unsigned i = 1; i < PIPE; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign tap = dly[PIPE-1];
        end else begin : g_nodly
            assign tap = pay_in;
        end
    endgenerate

    // Colour source: renderer, or the bar pattern when enabled.
    always_comb begin
        col_r = red_in;
        col_g = green_in;
        col_b = blue_in;
`ifdef VGA_TEST_PATTERN_EN
        if (tap_tm) begin
            col_r = {R_W{tap_bar[2]}};
            col_g = {G_W{tap_bar[1]}};
            col_b = {B_W{tap_bar[0]}};
        end
`endif
    end

    // Connector register: syncs at polarity, colour blanked outside active video.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            h_sync <= ~HS_ACT;
            v_sync <= ~VS_ACT;
            de     <= 1'b0;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else if (ce) begin
            h_sync <= tap_hs ? HS_ACT : ~HS_ACT;
            v_sync <= tap_vs ? VS_ACT : ~VS_ACT;
            de     <= tap_pr;
            red    <= tap_pr ? col_r : '0;
            green  <= tap_pr ? col_g : '0;
            blue   <= tap_pr ? col_b : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl: default horizontal timing with a short
// 13-line frame so several frames fit in a small cycle budget.
module tb_vga_timing_ctrl;

    localparam int HT  = 800;
    localparam int HA  = 640;
    localparam int HFP = 16;
    localparam int HSW = 96;
    localparam int VA  = 6;
    localparam int VFP = 2;
    localparam int VSW = 2;
    localparam int VT  = 13;
    localparam int LAT = 3;

    logic       pixel_clock = 1'b0;
    logic       reset = 1'b0;
    logic       ce = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    logic       test_mode = 1'b0;
`endif
    logic [9:0] x, y;
    logic       pix_req, line_start, frame_start;
    logic [2:0] red_in, green_in, red, green;
    logic [1:0] blue_in, blue;
    logic       h_sync, v_sync, de;

    int checks = 0;
    int errors = 0;

    vga_timing_ctrl #(
        .H_ADDR(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ADDR(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(0), .V_POL(0), .CNT_W(10),
        .R_W(3), .G_W(3), .B_W(2), .PIPE(2)
    ) dut (
        .pixel_clock(pixel_clock),
        .reset(reset),
        .ce(ce),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .x(x),
        .y(y),
        .pix_req(pix_req),
        .line_start(line_start),
        .frame_start(frame_start),
        .red_in(red_in),
        .green_in(green_in),
        .blue_in(blue_in),
        .h_sync(h_sync),
        .v_sync(v_sync),
        .de(de),
        .red(red),
        .green(green),
        .blue(blue)
    );

    always #5 pixel_clock = ~pixel_clock;

    // Renderer: two ce-qualified stages, colour = f(x, y) of the coordinate.
    logic [9:0] rx1, ry1, rx2, ry2;
    always @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            rx1 <= '0; ry1 <= '0; rx2 <= '0; ry2 <= '0;
        end else if (ce) begin
            rx1 <= x; ry1 <= y; rx2 <= rx1; ry2 <= ry1;
        end
    end
    assign red_in   = rx2[2:0];
    assign green_in = ry2[2:0];
    assign blue_in  = rx2[4:3];

    // Reference position: number of ce edges since reset was released.
    int k = 0;
    always @(posedge pixel_clock or posedge reset) begin
        if (reset) k <= 0;
        else if (ce) k <= k + 1;
    end

    bit tm_m = 1'b0;

    // Expected outputs at position kk, from plain mode arithmetic.
    function automatic logic [33:0] model(int kk, bit tm);
        int h, v, ch, cv, bar;
        logic hs, vs, dd;
        logic [2:0] r, g;
        logic [1:0] b;
        h = kk % HT;
        v = (kk / HT) % VT;
        hs = 1'b1; vs = 1'b1; dd = 1'b0; r = '0; g = '0; b = '0;
        if (kk >= LAT) begin
            ch = (kk - LAT) % HT;
            cv = ((kk - LAT) / HT) % VT;
            hs = !(ch >= HA + HFP && ch < HA + HFP + HSW);
            vs = !(cv >= VA + VFP && cv < VA + VFP + VSW);
            dd = (ch < HA) && (cv < VA);
            if (dd) begin
                if (tm) begin
                    bar = ch / (HA / 8);
                    r = ((bar & 4) != 0) ? 3'd7 : 3'd0;
                    g = ((bar & 2) != 0) ? 3'd7 : 3'd0;
                    b = ((bar & 1) != 0) ? 2'd3 : 2'd0;
                end else begin
                    r = 3'(ch % 8);
                    g = 3'(cv % 8);
                    b = 2'((ch / 8) % 4);
                end
            end
        end
        return {10'(h), 10'(v), (h < HA) && (v < VA), h == 0, (h == 0) && (v == 0),
                hs, vs, dd, r, g, b};
    endfunction

    logic [33:0] dut_vec;
    assign dut_vec = {x, y, pix_req, line_start, frame_start, h_sync, v_sync, de, red, green, blue};

    task automatic report();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    endtask

    task automatic chk(string nm, logic [33:0] act, logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (k=%0d t=%0t)", nm, act, exp, k, $time);
            if (errors >= 40) report();
        end
    endtask

    bit mon_en = 1'b0;
    always @(negedge pixel_clock) begin
        if (mon_en) chk("cycle_model", dut_vec, model(k, tm_m));
    end

    typedef struct {
        int k;
        int ex, ey;
        bit ls, fs, pr, hs, vs, de;
    } vec_t;

    vec_t vecs[23];

    task automatic tick();
        @(posedge pixel_clock);
        #2;
    endtask

    task automatic wait_k(int target, string nm);
        int guard = 0;
        while (k < target && guard < 20000) begin
            @(negedge pixel_clock);
            guard++;
        end
        if (k != target) chk({nm, "_timeout"}, 34'(k), 34'(target));
    endtask

    initial begin
        int rises, last_rise, periods, guard, rst_left;
        logic prev_ls;

        //          k      x    y   ls fs pr hs vs de
        vecs[0]  = '{0,     0,   0,  1, 1, 1, 1, 1, 0};
        vecs[1]  = '{2,     2,   0,  0, 0, 1, 1, 1, 0};
        vecs[2]  = '{3,     3,   0,  0, 0, 1, 1, 1, 1};
        vecs[3]  = '{639,   639, 0,  0, 0, 1, 1, 1, 1};
        vecs[4]  = '{640,   640, 0,  0, 0, 0, 1, 1, 1};
        vecs[5]  = '{643,   643, 0,  0, 0, 0, 1, 1, 0};
        vecs[6]  = '{658,   658, 0,  0, 0, 0, 1, 1, 0};
        vecs[7]  = '{659,   659, 0,  0, 0, 0, 0, 1, 0};
        vecs[8]  = '{754,   754, 0,  0, 0, 0, 0, 1, 0};
        vecs[9]  = '{755,   755, 0,  0, 0, 0, 1, 1, 0};
        vecs[10] = '{800,   0,   1,  1, 0, 1, 1, 1, 0};
        vecs[11] = '{803,   3,   1,  0, 0, 1, 1, 1, 1};
        vecs[12] = '{4800,  0,   6,  1, 0, 0, 1, 1, 0};
        vecs[13] = '{4803,  3,   6,  0, 0, 0, 1, 1, 0};
        vecs[14] = '{6402,  2,   8,  0, 0, 0, 1, 1, 0};
        vecs[15] = '{6403,  3,   8,  0, 0, 0, 1, 0, 0};
        vecs[16] = '{8002,  2,   10, 0, 0, 0, 1, 0, 0};
        vecs[17] = '{8003,  3,   10, 0, 0, 0, 1, 1, 0};
        vecs[18] = '{8799,  799, 10, 0, 0, 0, 1, 1, 0};
        vecs[19] = '{8800,  0,   11, 1, 0, 0, 1, 1, 0};
        vecs[20] = '{10399, 799, 12, 0, 0, 0, 1, 1, 0};
        vecs[21] = '{10400, 0,   0,  1, 1, 1, 1, 1, 0};
        vecs[22] = '{10403, 3,   0,  0, 0, 1, 1, 1, 1};

        // Reset state
        #1 reset = 1'b1;
        tick();
        mon_en = 1'b1;
        @(negedge pixel_clock);
        chk("rst_hsync", 34'(h_sync), 34'(1));
        chk("rst_vsync", 34'(v_sync), 34'(1));
        chk("rst_de", 34'(de), 34'(0));
        chk("rst_rgb", 34'({red, green, blue}), 34'(0));
        chk("rst_xy", 34'({x, y}), 34'(0));
        chk("rst_pulses", 34'({frame_start, line_start, pix_req}), 34'(3'b111));
        tick();
        reset = 1'b0;
        ce = 1'b1;

        // Table: boundaries of the first frame and the frame wrap
        for (int i = 0; i < 23; i++) begin
            wait_k(vecs[i].k, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_x", i), 34'(x), 34'(vecs[i].ex));
            chk($sformatf("vec%0d_y", i), 34'(y), 34'(vecs[i].ey));
            chk($sformatf("vec%0d_ls", i), 34'(line_start), 34'(vecs[i].ls));
            chk($sformatf("vec%0d_fs", i), 34'(frame_start), 34'(vecs[i].fs));
            chk($sformatf("vec%0d_pr", i), 34'(pix_req), 34'(vecs[i].pr));
            chk($sformatf("vec%0d_hs", i), 34'(h_sync), 34'(vecs[i].hs));
            chk($sformatf("vec%0d_vs", i), 34'(v_sync), 34'(vecs[i].vs));
            chk($sformatf("vec%0d_de", i), 34'(de), 34'(vecs[i].de));
        end

        // ce toggled every cycle: line period doubles
        rises = 0; last_rise = 0; periods = 0;
        prev_ls = line_start;
        for (int c = 0; c < 5000; c++) begin
            tick();
            ce = ~ce;
            @(negedge pixel_clock);
            if (line_start && !prev_ls) begin
                if (rises > 0) begin
                    chk("ce_line_period", 34'(c - last_rise), 34'(1600));
                    periods++;
                end
                rises++;
                last_rise = c;
            end
            prev_ls = line_start;
        end
        chk("ce_periods_seen", 34'(periods >= 2), 34'(1));
        tick();
        ce = 1'b1;

        // Reset mid-frame
        guard = 0;
        do begin
            @(negedge pixel_clock);
            guard++;
        end while (!(x == 10'd300 && y == 10'd3) && guard < 12000);
        chk("midrst_reach", 34'(guard < 12000), 34'(1));
        tick();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge pixel_clock);
            chk("midrst_sync", 34'({h_sync, v_sync}), 34'(2'b11));
            chk("midrst_de_rgb", 34'({de, red, green, blue}), 34'(0));
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge pixel_clock);
            if (c == 0) chk("postrst_xy", 34'({x, y}), 34'(0));
            chk($sformatf("postrst_de%0d", c), 34'(de), 34'(c == 3));
        end

        // Randomised ce and occasional resets against the model
        rst_left = 0;
        for (int c = 0; c < 12000; c++) begin
            tick();
            ce = ($urandom_range(0, 3) != 0);
            if (rst_left > 0) begin
                reset = 1'b1;
                rst_left--;
            end else begin
                reset = 1'b0;
                if ($urandom_range(0, 1999) == 0) rst_left = $urandom_range(1, 4);
            end
        end
        tick();
        reset = 1'b0;
        ce = 1'b1;

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars through the same delay
        tick();
        reset = 1'b1;
        test_mode = 1'b1;
        tm_m = 1'b1;
        tick();
        reset = 1'b0;
        wait_k(3, "tp0");
        chk("tp_x0_rgb", 34'({red, green, blue}), 34'(0));
        wait_k(82, "tp79");
        chk("tp_x79_rgb", 34'({red, green, blue}), 34'(0));
        wait_k(83, "tp80");
        chk("tp_x80_rgb", 34'({red, green, blue}), 34'(8'b000_000_11));
        wait_k(563, "tp560");
        chk("tp_x560_rgb", 34'({red, green, blue}), 34'(8'b111_111_11));
        wait_k(642, "tp639");
        chk("tp_x639_rgb", 34'({red, green, blue}), 34'(8'b111_111_11));
        wait_k(650, "tp_end");
`endif

        mon_en = 1'b0;
        report();
    end

endmodule
